// File: rtl/multdiv_ctrl_if.sv
// Handshake bundle between the execute stage, the multdiv sequencer and the
// shared multicycle multiplier/divider.
interface multdiv_ctrl_if;
    logic [4:0]  op_x;
    logic [4:0]  aluop_x;
    logic [31:0] rega_x;
    logic [31:0] regb_x;
    logic        md_ready;
    logic [31:0] md_result;
    logic        md_exception;
    logic        stall;
    logic        bubble_xm;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_operand_a;
    logic [31:0] md_operand_b;
    logic        result_valid;
    logic [31:0] result;
    logic        result_exception;
    logic        busy;

    modport master (
        output op_x, aluop_x, rega_x, regb_x, md_ready, md_result, md_exception,
        input  stall, bubble_xm, md_ctrl_mult, md_ctrl_div, md_operand_a, md_operand_b,
               result_valid, result, result_exception, busy
    );

    modport slave (
        input  op_x, aluop_x, rega_x, regb_x, md_ready, md_result, md_exception,
        output stall, bubble_xm, md_ctrl_mult, md_ctrl_div, md_operand_a, md_operand_b,
               result_valid, result, result_exception, busy
    );
endinterface

// File: rtl/multdiv_ctrl.sv
// Sequencer that freezes the pipeline around a mult/div, drives the shared
// multdiv unit and injects its result (or a timeout exception) into X/M.
module multdiv_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input logic          clock,
    input logic          reset,
    multdiv_ctrl_if.slave bus
);
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_MULT = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;
    localparam logic [6:0] CNT_LAST = 7'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state;
    logic [6:0]  cnt;
    logic        stall_hold;
    logic        req;
    logic        req_div;

    assign req_div = (bus.aluop_x == ALU_DIV);
    assign req     = (bus.op_x == OP_RTYPE) && ((bus.aluop_x == ALU_MULT) || req_div);

    // The IDLE request must freeze the front end in the same cycle it is decoded;
    // the reset term keeps that combinational path quiet while reset is held.
    assign bus.stall     = reset && (stall_hold || ((state == IDLE) && req));
    assign bus.bubble_xm = bus.stall;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                <= IDLE;
            cnt                  <= '0;
            stall_hold           <= 1'b0;
            bus.busy             <= 1'b0;
            bus.md_ctrl_mult     <= 1'b0;
            bus.md_ctrl_div      <= 1'b0;
            bus.md_operand_a     <= '0;
            bus.md_operand_b     <= '0;
            bus.result_valid     <= 1'b0;
            bus.result           <= '0;
            bus.result_exception <= 1'b0;
        end else begin
            bus.md_ctrl_mult <= 1'b0;
            bus.md_ctrl_div  <= 1'b0;
            bus.result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        bus.md_operand_a <= bus.rega_x;
                        bus.md_operand_b <= bus.regb_x;
                        bus.md_ctrl_mult <= !req_div;
                        bus.md_ctrl_div  <= req_div;
                        stall_hold       <= 1'b1;
                        bus.busy         <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.md_ready) begin
                        bus.result           <= bus.md_result;
                        bus.result_exception <= bus.md_exception;
                        bus.result_valid     <= 1'b1;
                        stall_hold           <= 1'b0;
                        state                <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        bus.result           <= '0;
                        bus.result_exception <= 1'b1;
                        bus.result_valid     <= 1'b1;
                        stall_hold           <= 1'b0;
                        state                <= DONE;
                    end else begin
                        cnt <= cnt + 7'd1;
                    end
                end
                DONE: begin
                    // The instruction still in D/X is the one just completed, so req is ignored.
                    bus.busy             <= 1'b0;
                    bus.md_operand_a     <= '0;
                    bus.md_operand_b     <= '0;
                    bus.result           <= '0;
                    bus.result_exception <= 1'b0;
                    state                <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: a stimulus process issues mult/div requests
// and a multdiv responder, a monitor process compares every cycle against the queue.
module tb_multdiv_ctrl;
    localparam int TIMEOUT = 12;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    multdiv_ctrl_if bus();

    multdiv_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int          t0;
        int          done;
        bit          div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          exc;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    // Reference multiplier/divider: signed 32-bit arithmetic with overflow flag.
    function automatic void md_model(input bit div, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output bit x);
        longint p;
        if (!div) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            x = (p != longint'($signed(r)));
        end else if (b == 32'd0) begin
            r = 32'd0;
            x = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            x = 1'b1;
        end else begin
            r = 32'($signed(a) / $signed(b));
            x = 1'b0;
        end
    endfunction

    task automatic drive_nonreq();
        logic [4:0] op;
        logic [4:0] alu;
        op  = 5'($urandom);
        alu = 5'($urandom);
        if (op == 5'd0 && (alu == 5'b00110 || alu == 5'b00111)) op = 5'd1;
        bus.op_x     = op;
        bus.aluop_x  = alu;
        bus.rega_x   = $urandom;
        bus.regb_x   = $urandom;
        bus.md_ready = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            drive_nonreq();
        end
    endtask

    // d = WAIT cycle (1-based) on which md_ready pulses; 0 means never.
    task automatic run_txn(input bit div, input logic [31:0] a, input logic [31:0] b,
                           input int d, input bit issue_pulse);
        exp_t        e;
        logic [31:0] r;
        bit          x;
        @(negedge clock);
        md_model(div, a, b, r, x);
        e.t0 = cyc;
        e.div = div;
        e.a = a;
        e.b = b;
        if (d == 0 || d > TIMEOUT) begin
            e.done = cyc + TIMEOUT + 2;
            e.res  = 32'd0;
            e.exc  = 1'b1;
        end else begin
            e.done = cyc + d + 2;
            e.res  = r;
            e.exc  = x;
        end
        bus.op_x     = 5'd0;
        bus.aluop_x  = div ? 5'b00111 : 5'b00110;
        bus.rega_x   = a;
        bus.regb_x   = b;
        bus.md_ready = 1'b0;
        sbq.push_back(e);
        for (int c = 1; c <= e.done - e.t0; c++) begin
            @(negedge clock);
            bus.md_ready = 1'b0;
            if (issue_pulse && c == 1) begin
                bus.md_ready     = 1'b1;
                bus.md_result    = 32'hDEAD_BEEF;
                bus.md_exception = 1'b1;
            end
            if (d != 0 && c == d + 1) begin
                bus.md_ready     = 1'b1;
                bus.md_result    = r;
                bus.md_exception = x;
            end
        end
    endtask

    // Monitor: derives every output's expected value from the head transaction.
    initial begin
        exp_t h;
        bit   act;
        bit   stall_e, busy_e, rv_e, mult_e, div_e;
        forever begin
            @(negedge clock);
            #2;
            act = (sbq.size() > 0);
            if (act) h = sbq[0];
            stall_e = act && cyc >= h.t0 && cyc < h.done;
            busy_e  = act && cyc > h.t0 && cyc <= h.done;
            rv_e    = act && cyc == h.done;
            mult_e  = act && cyc == h.t0 + 1 && !h.div;
            div_e   = act && cyc == h.t0 + 1 && h.div;
            chk("stall", bus.stall, stall_e);
            chk("bubble_xm", bus.bubble_xm, stall_e);
            chk("busy", bus.busy, busy_e);
            chk("result_valid", bus.result_valid, rv_e);
            chk("md_ctrl_mult", bus.md_ctrl_mult, mult_e);
            chk("md_ctrl_div", bus.md_ctrl_div, div_e);
            chk("md_operand_a", bus.md_operand_a, busy_e ? h.a : 32'd0);
            chk("md_operand_b", bus.md_operand_b, busy_e ? h.b : 32'd0);
            if (rv_e) begin
                chk("result", bus.result, h.res);
                chk("result_exception", bus.result_exception, h.exc);
                void'(sbq.pop_front());
            end else if (!busy_e) begin
                chk("result_idle", bus.result, 32'd0);
                chk("result_exception_idle", bus.result_exception, 1'b0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        bit          kind;
        logic [31:0] a;
        logic [31:0] b;
        int          d;
        bus.op_x = 5'd0;
        bus.aluop_x = 5'd0;
        bus.rega_x = 32'd0;
        bus.regb_x = 32'd0;
        bus.md_ready = 1'b0;
        bus.md_result = 32'd0;
        bus.md_exception = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        idle_cycles(2);

        run_txn(1'b0, 32'd7, 32'd6, 10, 1'b0);
        idle_cycles(1);
        run_txn(1'b1, 32'd5, 32'd0, 3, 1'b0);
        idle_cycles(2);
        run_txn(1'b0, $urandom, $urandom, 0, 1'b0);
        idle_cycles(1);
        run_txn(1'b1, 32'd100, 32'd7, 2, 1'b1);
        run_txn(1'b0, 32'hFFFF_FFFD, 32'd9, TIMEOUT, 1'b0);
        run_txn(1'b0, 32'd3, 32'd4, 1, 1'b0);
        run_txn(1'b0, 32'h4000_0000, 32'd4, 4, 1'b0);
        idle_cycles(1);

        for (int n = 0; n < 30; n++) begin
            kind = 1'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            d = $urandom_range(0, TIMEOUT);
            run_txn(kind, a, b, d, (d >= 2) && ($urandom_range(0, 3) == 0));
            idle_cycles($urandom_range(0, 2));
        end

        // Reset pulse in the fifth WAIT cycle, then a stale md_ready in IDLE.
        @(negedge clock);
        begin
            exp_t e;
            e.t0 = cyc;
            e.done = cyc + TIMEOUT + 2;
            e.div = 1'b0;
            e.a = 32'd11;
            e.b = 32'd13;
            e.res = 32'd0;
            e.exc = 1'b1;
            bus.op_x = 5'd0;
            bus.aluop_x = 5'b00110;
            bus.rega_x = 32'd11;
            bus.regb_x = 32'd13;
            sbq.push_back(e);
        end
        repeat (6) @(negedge clock);
        sbq.delete();
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        drive_nonreq();
        bus.md_ready = 1'b1;
        bus.md_result = 32'd143;
        bus.md_exception = 1'b0;
        @(negedge clock);
        bus.md_ready = 1'b1;
        idle_cycles(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
